rram_pulse_ctrl: RTL and testbench
==================================

// Module: rram_pulse_ctrl
// PURPOSE
//  Digital pulse sequencer directly upstream of the RRAM 1T1R test array.
//  Takes one READ/SET/RESET command at a time and drives the array's row and
//  column enables with timed setup, pulse and hold phases.
//  The level-shift and pad switches sit between it and the analog pins.
//  READ commands sample the external sense comparator and return the cell state.
// PARAMETERS
//  CNT_W   8   width of the pulse-width and gap counters (cycles)
//  PCNT_W  16  width of the saturating program-pulse counter
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  resetn       in   1       synchronous active-low reset
//  cmd_valid    in   1       command valid
//  cmd_ready    out  1       block can accept a command
//  cmd_op       in   2       00 READ, 01 SET, 10 RESET, 11 reserved
//  cmd_row      in   1       selects WL0/WL1
//  cmd_col      in   1       selects BL0/BR0 or BL1/BR1 column pair
//  cmd_width    in   CNT_W   pulse length in cycles; 0 treated as 1
//  cmd_gap      in   CNT_W   setup cycles and hold cycles; 0 skips both phases
//  abort        in   1       abandon the command in flight
//  sense_in     in   1       comparator output, already synchronised
//  wl_en        out  2       one-hot wordline enable (program path)
//  re_wl_en     out  2       one-hot wordline enable (read path)
//  bl_en        out  2       one-hot program column drive (TE side)
//  sl_en        out  2       one-hot program column drive (SL side)
//  re_bl_en     out  2       one-hot read column drive
//  rsp_valid    out  1       response valid
//  rsp_ready    in   1       response consumed
//  rsp_data     out  1       READ result (1 = low resistance); 0 otherwise
//  rsp_err      out  1       aborted or reserved opcode
//  busy         out  1       high in any state other than IDLE
//  pulse_count  out  PCNT_W  number of SET/RESET pulses issued, saturating
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_ready 0 during reset, 1 from the first cycle after),
//   FSM goes to IDLE, pulse_count cleared.
//  FSM states: IDLE, SETUP, PULSE, HOLD, RESP.
//   IDLE:  cmd_ready=1.
//          cmd_valid&cmd_ready latches op/row/col/width/gap.
//          Reserved op -> RESP with err=1; otherwise gap>0 -> SETUP, gap==0 -> PULSE.
//   SETUP: gap cycles. Selected row enable only: wl_en for SET/RESET, re_wl_en for READ.
//   PULSE: max(width,1) cycles. Row enable held. Column drive added:
//          SET bl_en[col], RESET sl_en[col], READ re_bl_en[col].
//          READ samples sense_in on the last PULSE cycle into rsp_data.
//   HOLD:  gap>0: gap cycles, row enable only. gap==0: skipped.
//   RESP:  all drivers low. rsp_valid=1 until rsp_ready; then -> IDLE.
//          rsp_data/rsp_err stay stable while rsp_valid is high.
//  All drivers are decoded from registered state only; no combinational path
//   from any input to a driver.
//  bl_en and sl_en are never both nonzero. Column drive is never on without
//   the row enable on.
//  Timing, acceptance edge = E0: SETUP occupies cycles 1..G, PULSE G+1..G+W,
//   HOLD G+W+1..2G+W, rsp_valid rises in cycle 2G+W+1 (W=max(width,1), G=gap).
//   Reserved op: rsp_valid in cycle 1.
//  pulse_count increments by 1 on each entry to PULSE for SET/RESET.
//   Saturates at all-ones. READ never counts.
//  abort in SETUP/PULSE/HOLD: next cycle all drivers 0, state RESP, rsp_err=1,
//   rsp_data=0. Pulse already counted stays counted. abort ignored in IDLE and RESP.
//  abort and cmd_valid in the same IDLE cycle: command accepted, abort ignored.
//  Counter wrap: an internal down-counter reloads at each phase entry. A width or
//   gap of all-ones gives exactly 2^CNT_W-1 cycles.
//  resetn low mid-command: drivers low on the next edge, no response issued.
// TESTING
//  SET row0 col1 width=3 gap=2 -> wl_en=01 cycles 1-7, bl_en=10 cycles 3-5,
//   rsp_valid cycle 8, err=0, pulse_count=1.
//  READ row1 col0 width=4 gap=0, sense_in=1 during PULSE -> re_wl_en=10 and
//   re_bl_en=01 cycles 1-4, rsp_data=1, pulse_count unchanged.
//  RESET width=0 gap=0 -> sl_en active exactly 1 cycle; hold rsp_ready low 5
//   cycles -> rsp_valid stays 1, cmd_ready stays 0 until consumed.
//  SET width=10 gap=1, abort in cycle 4 -> drivers 0 in cycle 5,
//   rsp_err=1, rsp_data=0.
//  cmd_op=11 -> rsp_valid cycle 1, rsp_err=1, no driver ever asserted.
//  Preload pulse_count=16'hFFFF, issue SET -> stays 16'hFFFF. resetn low during
//   PULSE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rram_pulse_ctrl.sv
// rtl/rram_pulse_ctrl.sv - timed READ/SET/RESET pulse sequencer for the RRAM 1T1R test array
//
// Accepts one command at a time and walks it through SETUP, PULSE and HOLD
// phases. Each phase drives the selected row and column enables. READ results
// and abort or reserved-opcode errors are returned through a valid/ready
// response.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cmd_*                command handshake and fields (op, row, col, width, gap)
//   abort                abandon the command in flight (SETUP/PULSE/HOLD only)
//   sense_in             synchronised sense comparator, sampled on last READ pulse cycle
//   wl_en, re_wl_en      one-hot wordline enables (program / read path)
//   bl_en, sl_en         one-hot program column drives (TE side / SL side)
//   re_bl_en             one-hot read column drive
//   rsp_*                response handshake, READ data and error flag
//   busy                 sequencer not idle
//   pulse_count          saturating count of SET/RESET pulses issued
module rram_pulse_ctrl #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_row,
  input  logic              cmd_col,
  input  logic [CNT_W-1:0]  cmd_width,
  input  logic [CNT_W-1:0]  cmd_gap,
  input  logic              abort,
  input  logic              sense_in,
  output logic [1:0]        wl_en,
  output logic [1:0]        re_wl_en,
  output logic [1:0]        bl_en,
  output logic [1:0]        sl_en,
  output logic [1:0]        re_bl_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [PCNT_W-1:0] pulse_count
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [1:0]          op_q;
  logic                row_q, col_q;
  logic [CNT_W-1:0]    width_q, gap_q;
  logic                rsp_data_q, rsp_err_q;
  logic                data_nxt, err_nxt;
  logic [PCNT_W-1:0]   pulse_count_q;
  logic                ready_q;
  logic                latch_cmd;
  logic                count_pulse;

  // The down-counter is loaded with (length - 1) at each phase entry. The phase
  // ends when it reads zero, so an all-ones length gives exactly 2^CNT_W-1
  // cycles. A zero width is stretched to one cycle.
  logic [CNT_W-1:0]    cmd_w_m1, cmd_g_m1, width_m1, gap_m1;
  logic [1:0]          row_1h, col_1h;
  logic                prog_op, row_on, col_on;

  assign cmd_w_m1 = (cmd_width == '0) ? '0 : cmd_width - 1'b1;
  assign cmd_g_m1 = cmd_gap - 1'b1;
  assign width_m1 = (width_q == '0) ? '0 : width_q - 1'b1;
  assign gap_m1   = gap_q - 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_q          <= OP_READ;
      row_q         <= 1'b0;
      col_q         <= 1'b0;
      width_q       <= '0;
      gap_q         <= '0;
      rsp_data_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      pulse_count_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rsp_data_q <= data_nxt;
      rsp_err_q  <= err_nxt;
      // Holds cmd_ready low through reset and releases it one cycle after.
      ready_q    <= 1'b1;
      if (latch_cmd) begin
        op_q    <= cmd_op;
        row_q   <= cmd_row;
        col_q   <= cmd_col;
        width_q <= cmd_width;
        gap_q   <= cmd_gap;
      end
      if (count_pulse && (pulse_count_q != '1)) begin
        pulse_count_q <= pulse_count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    data_nxt    = rsp_data_q;
    err_nxt     = rsp_err_q;
    latch_cmd   = 1'b0;
    count_pulse = 1'b0;

    case (state)
      S_IDLE: begin
        // abort is deliberately not looked at here
        if (cmd_valid && ready_q) begin
          latch_cmd = 1'b1;
          data_nxt  = 1'b0;
          err_nxt   = 1'b0;
          if (cmd_op == OP_RSVD) begin
            state_nxt = S_RESP;
            err_nxt   = 1'b1;
          end else if (cmd_gap != '0) begin
            state_nxt = S_SETUP;
            cnt_nxt   = cmd_g_m1;
          end else begin
            state_nxt   = S_PULSE;
            cnt_nxt     = cmd_w_m1;
            count_pulse = (cmd_op != OP_READ);
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          state_nxt = S_RESP;
          err_nxt   = 1'b1;
          data_nxt  = 1'b0;
        end else if (cnt == '0) begin
          state_nxt   = S_PULSE;
          cnt_nxt     = width_m1;
          count_pulse = (op_q != OP_READ);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      S_PULSE: begin
        if (abort) begin
          state_nxt = S_RESP;
          err_nxt   = 1'b1;
          data_nxt  = 1'b0;
        end else if (cnt == '0) begin
          if (op_q == OP_READ) begin
            data_nxt = sense_in;
          end
          if (gap_q != '0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = gap_m1;
          end else begin
            state_nxt = S_RESP;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      S_HOLD: begin
        if (abort) begin
          state_nxt = S_RESP;
          err_nxt   = 1'b1;
          data_nxt  = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
          data_nxt  = 1'b0;
          err_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Drivers depend only on registered state and latched command fields, so no
  // input can glitch the array enables combinationally. A reserved opcode never
  // reaches SETUP/PULSE/HOLD, so prog_op only needs to separate READ from SET/RESET.
  assign row_1h  = row_q ? 2'b10 : 2'b01;
  assign col_1h  = col_q ? 2'b10 : 2'b01;
  assign prog_op = (op_q == OP_SET) || (op_q == OP_RESET);
  assign row_on  = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
  assign col_on  = (state == S_PULSE);

  assign wl_en    = (row_on && prog_op)              ? row_1h : 2'b00;
  assign re_wl_en = (row_on && (op_q == OP_READ))    ? row_1h : 2'b00;
  assign bl_en    = (col_on && (op_q == OP_SET))     ? col_1h : 2'b00;
  assign sl_en    = (col_on && (op_q == OP_RESET))   ? col_1h : 2'b00;
  assign re_bl_en = (col_on && (op_q == OP_READ))    ? col_1h : 2'b00;

  assign cmd_ready   = ready_q && (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_rram_pulse_ctrl.sv
// tb/tb_rram_pulse_ctrl.sv - self-checking bench for rram_pulse_ctrl
module tb_rram_pulse_ctrl;

  localparam int CNT_W  = 8;
  localparam int PCNT_W = 4;
  localparam int PC_MAX = (1 << PCNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic              cmd_row = 1'b0;
  logic              cmd_col = 1'b0;
  logic [CNT_W-1:0]  cmd_width = '0;
  logic [CNT_W-1:0]  cmd_gap = '0;
  logic              abort = 1'b0;
  logic              sense_in = 1'b0;
  logic [1:0]        wl_en, re_wl_en, bl_en, sl_en, re_bl_en;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_data, rsp_err, busy;
  logic [PCNT_W-1:0] pulse_count;

  int errors = 0;
  int checks = 0;
  int exp_pc = 0;

  rram_pulse_ctrl #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_width(cmd_width), .cmd_gap(cmd_gap),
    .abort(abort), .sense_in(sense_in),
    .wl_en(wl_en), .re_wl_en(re_wl_en), .bl_en(bl_en), .sl_en(sl_en), .re_bl_en(re_bl_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] drv_obs();
    return {wl_en, re_wl_en, bl_en, sl_en, re_bl_en};
  endfunction

  // Expected drivers in cycle k after acceptance, from the phase timeline:
  // SETUP 1..G, PULSE G+1..G+W, HOLD G+W+1..2G+W.
  function automatic logic [9:0] exp_drv(input logic [1:0] op, input logic row, input logic col,
                                         input int g, input int w, input int k);
    logic [1:0] r1, c1, wl, rwl, bl, sl, rbl;
    logic in_pulse;
    r1 = row ? 2'b10 : 2'b01;
    c1 = col ? 2'b10 : 2'b01;
    in_pulse = (k > g) && (k <= g + w);
    wl  = (op != 2'b00) ? r1 : 2'b00;
    rwl = (op == 2'b00) ? r1 : 2'b00;
    bl  = (op == 2'b01 && in_pulse) ? c1 : 2'b00;
    sl  = (op == 2'b10 && in_pulse) ? c1 : 2'b00;
    rbl = (op == 2'b00 && in_pulse) ? c1 : 2'b00;
    return {wl, rwl, bl, sl, rbl};
  endfunction

  // ab: cycle in which abort is raised (0 = none); dly: cycles rsp_ready held low;
  // sense_sel: 0/1 fixed sense level, 2 random each cycle.
  task automatic run_cmd(input logic [1:0] op, input logic row, input logic col,
                         input logic [7:0] w, input logic [7:0] g,
                         input int ab, input int dly, input int sense_sel);
    int  wc, gc, fin, tries;
    bit  reserved, aborted;
    logic exp_data;
    reserved = (op == 2'b11);
    wc = (w == 0) ? 1 : int'(w);
    gc = int'(g);
    aborted = !reserved && (ab >= 1) && (ab <= 2 * gc + wc);
    fin = reserved ? 0 : (aborted ? ab : 2 * gc + wc);
    exp_data = 1'b0;

    @(negedge clk);
    tries = 0;
    while (!cmd_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_col   = col;
    cmd_width = w;
    cmd_gap   = g;
    abort     = 1'($urandom_range(0, 1));  // must be ignored in IDLE

    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = 1'b0;
      chk("drivers", drv_obs(), exp_drv(op, row, col, gc, wc, k));
      chk("busy_active", busy, 1);
      chk("rsp_valid_early", rsp_valid, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      sense_in = (sense_sel > 1) ? 1'($urandom_range(0, 1)) : sense_sel[0];
      if (k == gc + wc && op == 2'b00) exp_data = sense_in;
      if (k == ab) abort = 1'b1;
    end
    if (aborted) exp_data = 1'b0;
    if (!reserved && op != 2'b00 && !(aborted && ab <= gc) && exp_pc < PC_MAX) exp_pc++;

    for (int d = 0; d <= dly; d++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = 1'($urandom_range(0, 1));  // must be ignored in RESP
      chk("drivers_resp", drv_obs(), 10'd0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, (reserved || aborted) ? 1 : 0);
      chk("cmd_ready_resp", cmd_ready, 0);
      rsp_ready = (d == dly);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    abort = 1'b0;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("cmd_ready_done", cmd_ready, 1);
    chk("busy_done", busy, 0);
    chk("pulse_count", pulse_count, exp_pc);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_drivers", drv_obs(), 10'd0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse_count", pulse_count, 0);
    chk("rst_rsp", {rsp_data, rsp_err}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    run_cmd(2'b01, 1'b0, 1'b1, 8'd3,  8'd2, 0, 0, 2);
    run_cmd(2'b00, 1'b1, 1'b0, 8'd4,  8'd0, 0, 0, 1);
    run_cmd(2'b10, 1'b0, 1'b0, 8'd0,  8'd0, 0, 5, 2);
    run_cmd(2'b01, 1'b0, 1'b0, 8'd10, 8'd1, 4, 0, 2);
    run_cmd(2'b11, 1'b1, 1'b1, 8'd7,  8'd3, 0, 2, 2);
    run_cmd(2'b00, 1'b0, 1'b1, 8'd255, 8'd255, 0, 1, 0);
    run_cmd(2'b10, 1'b1, 1'b1, 8'd2,  8'd1, 1, 0, 2);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] w, g;
      w = 8'($urandom_range(0, 5));
      g = 8'($urandom_range(0, 4));
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              w, g, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * g + 8)) : 0,
              int'($urandom_range(0, 3)), 2);
    end

    for (int i = 0; i <= PC_MAX + 1; i++) begin
      run_cmd(2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'd0, 8'd0, 0, 0, 2);
    end
    chk("pulse_count_sat", pulse_count, PC_MAX);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_row = 1'b1; cmd_col = 1'b0; cmd_width = 8'd5; cmd_gap = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_bl", bl_en, 2'b01);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_drivers", drv_obs(), 10'd0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulse_count", pulse_count, 0);
    exp_pc = 0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_cmd_ready", cmd_ready, 1);
      chk("postrst_no_rsp", rsp_valid, 0);
    end
    run_cmd(2'b10, 1'b0, 1'b1, 8'd2, 8'd1, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
